sar_result_serializer: RTL and testbench

//  Reader side of the 4-bit SAR conversion interface: captures each finished code (bitout + conv_done)

---
 rtl/sar_pkg.sv | 20 ++
 rtl/sar_result_fifo.sv | 67 ++++++
 rtl/sar_result_serializer.sv | 188 ++++++++++++++++++
 tb/tb_sar_result_serializer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
// Shared definitions for the SAR result serializer: transmit state encoding,
// the native result width and a helper that gives the length of one serial frame.
package sar_pkg;

  localparam int SAR_DATA_W = 4;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  // Clock cycles occupied by one frame: start + data + optional parity + stop.
  function automatic int frame_clks(input int data_w, input int clks_per_bit, input bit parity);
    return (data_w + 2 + (parity ? 1 : 0)) * clks_per_bit;
  endfunction

endpackage

// File: rtl/sar_result_fifo.sv
// Synchronous result buffer (DATA_W x DEPTH, DEPTH a power of two).
// Head word is presented combinationally. A push while full is only taken
// when a pop happens in the same cycle, so the freed slot receives the new word.
module sar_result_fifo #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              do_push;
  logic              do_pop;

  assign full     = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem[rd_ptr_q];
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/sar_result_serializer.sv
// SAR result serializer: captures each finished conversion code on the rising
// edge of conv_done into a small FIFO and sends it out as an asynchronous
// frame (start 0, data MSB first, optional even parity, stop 1) on ser_out.
// Optional parity bit is enabled by defining SAR_SER_PARITY_EN.
//
// state     | meaning
// TX_IDLE   | line high, waiting for tx_en and a buffered word
// TX_START  | start bit (0) for one bit period
// TX_DATA   | DATA_W data bits, MSB first
// TX_PARITY | even parity over the data bits (SAR_SER_PARITY_EN only)
// TX_STOP   | stop bit (1), then back to idle for at least one cycle
module sar_result_serializer
  import sar_pkg::*;
#(
  parameter int DATA_W       = SAR_DATA_W,
  parameter int FIFO_DEPTH   = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_W-1:0]             bitout,
  input  logic                          conv_done,
  input  logic                          tx_en,
  input  logic                          clr_ovf,
  output logic                          ser_out,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  logic              conv_done_q;
  logic              capture;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;

  tx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              ser_out_q, ser_out_d;
  logic              overflow_q, overflow_d;
`ifdef SAR_SER_PARITY_EN
  logic              parity_q;
`endif

  assign capture    = conv_done & ~conv_done_q;
  assign ser_out    = ser_out_q;
  assign tx_busy    = (state_q != TX_IDLE);
  assign overflow   = overflow_q;

  sar_result_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (capture),
    .push_data (bitout),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // A capture that finds the buffer full with no pop to make room is lost; set wins over clear.
  always_comb begin
    overflow_d = overflow_q;
    if (capture && fifo_full && !pop) overflow_d = 1'b1;
    else if (clr_ovf)                 overflow_d = 1'b0;
  end

  // Transmit FSM next-state, plus the registered line level for the next cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (tx_en && !fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          state_d = TX_START;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      TX_START: begin
        if (cnt_q == CNT_LAST) begin
          state_d = TX_DATA;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
`ifdef SAR_SER_PARITY_EN
            state_d = TX_PARITY;
`else
            state_d = TX_STOP;
`endif
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = shift_q << 1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef SAR_SER_PARITY_EN
      TX_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          state_d = TX_STOP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      TX_STOP: begin
        if (cnt_q == CNT_LAST) begin
          state_d = TX_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = TX_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase

    case (state_d)
      TX_START:  ser_out_d = 1'b0;
      TX_DATA:   ser_out_d = shift_d[DATA_W-1];
`ifdef SAR_SER_PARITY_EN
      TX_PARITY: ser_out_d = parity_q;
`endif
      default:   ser_out_d = 1'b1;
    endcase
  end

  // Edge-detect history, FSM, shift register, line and overflow registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conv_done_q <= 1'b0;
      state_q     <= TX_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      ser_out_q   <= 1'b1;
      overflow_q  <= 1'b0;
    end else begin
      conv_done_q <= conv_done;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      ser_out_q   <= ser_out_d;
      overflow_q  <= overflow_d;
    end
  end

`ifdef SAR_SER_PARITY_EN
  // Parity is computed once from the popped word, before shifting destroys it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   parity_q <= 1'b0;
    else if (pop) parity_q <= ^fifo_head;
  end
`endif

endmodule

// File: tb/tb_sar_result_serializer.sv
// Testbench for sar_result_serializer (default build; parity frames are
// expected automatically when SAR_SER_PARITY_EN is defined for the bench too).
module tb_sar_result_serializer;

  localparam int DW    = 4;
  localparam int DEPTH = 4;
  localparam int CPB   = 4;
`ifdef SAR_SER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME = (DW + 2 + PAR) * CPB;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] bitout;
  logic          conv_done;
  logic          tx_en;
  logic          clr_ovf;
  logic          ser_out;
  logic          tx_busy;
  logic [2:0]    fifo_count;
  logic          overflow;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];

  sar_result_serializer #(
    .DATA_W       (DW),
    .FIFO_DEPTH   (DEPTH),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bitout     (bitout),
    .conv_done  (conv_done),
    .tx_en      (tx_en),
    .clr_ovf    (clr_ovf),
    .ser_out    (ser_out),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Line level expected i cycles into a frame carrying word w.
  function automatic logic exp_level(input logic [DW-1:0] w, input int i);
    int p;
    p = i / CPB;
    if (p == 0) return 1'b0;
    if (p <= DW) return w[DW-p];
    if (PAR != 0 && p == DW + 1) return ^w;
    return 1'b1;
  endfunction

  task automatic pulse(input logic [DW-1:0] w);
    bitout    = w;
    conv_done = 1'b1;
    @(negedge clk);
    conv_done = 1'b0;
  endtask

  // Waits for a frame, records it and compares against the oldest expected word.
  task automatic recv_frame(input string name, output int wait_n);
    logic [DW-1:0]    w;
    logic [FRAME-1:0] act;
    logic [FRAME-1:0] expv;
    bit               busy_ok;
    wait_n = 0;
    while (tx_busy !== 1'b1 && wait_n < 300) begin
      @(negedge clk);
      wait_n++;
    end
    n_cmp++;
    if (tx_busy !== 1'b1) begin
      n_err++;
      $display("FAIL %s start: tx_busy=%b after %0d clks, required 1", name, tx_busy, wait_n);
      return;
    end
    w = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    busy_ok = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      act[FRAME-1-i]  = ser_out;
      expv[FRAME-1-i] = exp_level(w, i);
      if (tx_busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
    end
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s frame word=%h: got %b, required %b", name, w, act, expv);
    end
    n_cmp++;
    if (!busy_ok) begin
      n_err++;
      $display("FAIL %s busy: tx_busy dropped during the %0d-clk frame, required high throughout", name, FRAME);
    end
    n_cmp++;
    if (tx_busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s end: tx_busy=%b after frame, required 0", name, tx_busy);
    end
  endtask

  task automatic test_reset();
    logic [DW-1:0] w;
    int gap;
    reset = 1'b0; bitout = '0; conv_done = 1'b0; tx_en = 1'b1; clr_ovf = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (ser_out !== 1'b1)  begin n_err++; $display("FAIL reset ser_out: got %b, required 1", ser_out); end
    n_cmp++; if (tx_busy !== 1'b0)  begin n_err++; $display("FAIL reset tx_busy: got %b, required 0", tx_busy); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL reset fifo_count: got %0d, required 0", fifo_count); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset overflow: got %b, required 0", overflow); end
    reset = 1'b1;
    @(negedge clk);
    w = 4'($urandom_range(0, 15));
    pulse(w);
    repeat (8) @(negedge clk);
    n_cmp++; if (tx_busy !== 1'b1) begin n_err++; $display("FAIL midframe busy: got %b, required 1", tx_busy); end
    reset = 1'b0;
    #1;
    n_cmp++; if (ser_out !== 1'b1)  begin n_err++; $display("FAIL abort ser_out: got %b, required 1", ser_out); end
    n_cmp++; if (tx_busy !== 1'b0)  begin n_err++; $display("FAIL abort tx_busy: got %b, required 0", tx_busy); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL abort fifo_count: got %0d, required 0", fifo_count); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    w = 4'($urandom_range(0, 15));
    exp_q.push_back(w);
    pulse(w);
    recv_frame("after_reset", gap);
  endtask

  task automatic test_single();
    logic [DW-1:0] w;
    int gap;
    exp_q.push_back(4'b1011);
    pulse(4'b1011);
    n_cmp++; if (tx_busy !== 1'b0 || fifo_count !== 3'd1) begin
      n_err++; $display("FAIL latency E: busy=%b count=%0d, required busy 0 count 1", tx_busy, fifo_count);
    end
    @(negedge clk);
    n_cmp++; if (tx_busy !== 1'b1 || ser_out !== 1'b0 || fifo_count !== 3'd0) begin
      n_err++; $display("FAIL latency E+1: busy=%b ser=%b count=%0d, required 1 0 0", tx_busy, ser_out, fifo_count);
    end
    recv_frame("b1011", gap);
    n_cmp++; if (gap !== 0) begin n_err++; $display("FAIL b1011 gap: got %0d, required 0", gap); end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      w = (k == 0) ? 4'b0111 : (k == 1) ? 4'b0101 : 4'($urandom_range(0, 15));
      exp_q.push_back(w);
      pulse(w);
      recv_frame("single", gap);
      n_cmp++; if (gap !== 1) begin n_err++; $display("FAIL single latency word=%h: got %0d, required 1", w, gap); end
    end
  endtask

  task automatic test_held();
    int gap;
    int peak;
    bit extra;
    peak = 0;
    exp_q.push_back(4'b0110);
    bitout = 4'b0110;
    conv_done = 1'b1;
    fork
      recv_frame("held", gap);
      begin
        repeat (3) begin
          @(negedge clk);
          if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
        conv_done = 1'b0;
        repeat (2) begin
          @(negedge clk);
          if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
      end
    join
    n_cmp++; if (peak !== 1) begin n_err++; $display("FAIL held peak: got %0d, required 1", peak); end
    extra = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (tx_busy !== 1'b0) extra = 1'b1;
    end
    n_cmp++; if (extra) begin n_err++; $display("FAIL held second frame: got busy, required idle"); end
  endtask

  task automatic test_tx_en_mid();
    logic [DW-1:0] w1, w2;
    int gap;
    bit extra;
    w1 = 4'($urandom_range(0, 15));
    w2 = 4'($urandom_range(0, 15));
    exp_q.push_back(w1);
    exp_q.push_back(w2);
    pulse(w1);
    fork
      recv_frame("txen_mid", gap);
      begin
        repeat (3) @(negedge clk);
        pulse(w2);
        tx_en = 1'b0;
      end
    join
    extra = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (tx_busy !== 1'b0) extra = 1'b1;
    end
    n_cmp++; if (extra || fifo_count !== 3'd1) begin
      n_err++; $display("FAIL txen_off: busy_seen=%b count=%0d, required 0 and 1", extra, fifo_count);
    end
    tx_en = 1'b1;
    recv_frame("txen_resume", gap);
  endtask

  task automatic test_overflow();
    logic [DW-1:0] w;
    int gap;
    tx_en = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      w = 4'($urandom_range(0, 15));
      if (k < DEPTH) exp_q.push_back(w);
      clr_ovf = (k == 4);
      pulse(w);
      clr_ovf = 1'b0;
      @(negedge clk);
    end
    n_cmp++; if (fifo_count !== 3'd4) begin n_err++; $display("FAIL ovf count: got %0d, required 4", fifo_count); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf set: got %b, required 1", overflow); end
    tx_en = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      recv_frame("ovf_drain", gap);
      n_cmp++; if (gap !== 1) begin n_err++; $display("FAIL ovf gap %0d: got %0d, required 1", k, gap); end
    end
    n_cmp++; if (fifo_count !== 3'd0 || overflow !== 1'b1) begin
      n_err++; $display("FAIL ovf sticky: count=%0d ovf=%b, required 0 1", fifo_count, overflow);
    end
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf clear: got %b, required 0", overflow); end
  endtask

  task automatic test_full_pop();
    logic [DW-1:0] w;
    int gap;
    tx_en = 1'b0;
    @(negedge clk);
    for (int k = 0; k < DEPTH; k++) begin
      w = 4'($urandom_range(0, 15));
      exp_q.push_back(w);
      pulse(w);
      @(negedge clk);
    end
    w = 4'($urandom_range(0, 15));
    exp_q.push_back(w);
    tx_en = 1'b1;
    pulse(w);
    n_cmp++; if (fifo_count !== 3'd4 || overflow !== 1'b0 || tx_busy !== 1'b1) begin
      n_err++; $display("FAIL full_pop: count=%0d ovf=%b busy=%b, required 4 0 1", fifo_count, overflow, tx_busy);
    end
    for (int k = 0; k <= DEPTH; k++) recv_frame("full_pop", gap);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_held();
    test_tx_en_mid();
    test_overflow();
    test_full_pop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
